// File: rtl/mem_line_responder.sv
// mem_line_responder: main-memory line store answering cache fills (reads) and evictions (writes).
// Latency: BUS_R rises LATENCY cycles after the accepting edge; read data is valid with BUS_R.
// Backpressure: 4-phase handshake; BUS_R holds while BUS_EN stays high, then at least one idle cycle.
// Optional build macro: MEM_RESP_STATS_EN adds saturating rd_count / wr_count outputs.
module mem_line_responder #(
  parameter int ADDR_W  = 16,
  parameter int LINE_W  = 128,
  parameter int IDX_W   = 12,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              BUS_EN,
  input  logic              BUS_WR,
  input  logic [ADDR_W-1:0] BUS_ADDR,
  input  logic [LINE_W-1:0] BUS_WRITE,
  output logic              BUS_R,
  output logic [LINE_W-1:0] BUS_READ
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int         DEPTH    = 1 << IDX_W;
  // Counter is loaded on acceptance and counts down to the completing edge.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    BUSY = 3'b010,
    RESP = 3'b100
  } state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic              req_wr;
  logic [IDX_W-1:0]  req_idx;
  logic [LINE_W-1:0] req_dat;
  logic [IDX_W-1:0]  bus_idx;
  logic              done;
  logic              commit_wr;
  logic              unused_addr_bits;

  // Backing store: not reset, contents persist across clr.
  logic [LINE_W-1:0] mem [DEPTH];

  // Line index: byte offset bits and anything above the index are don't-care.
  assign bus_idx          = BUS_ADDR[IDX_W+3:4];
  assign unused_addr_bits = ^BUS_ADDR;

  // Completion strobe and the gated write commit (clr drops an uncommitted write).
  always_comb begin
    done      = (state == BUSY) && (cnt == 8'd0);
    commit_wr = done && req_wr && !clr;
  end

  // Handshake FSM: latch request in IDLE, count latency in BUSY, hold BUS_R in RESP.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      BUS_R    <= 1'b0;
      BUS_READ <= '0;
      cnt      <= '0;
      req_wr   <= 1'b0;
      req_idx  <= '0;
      req_dat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (BUS_EN) begin
            req_wr  <= BUS_WR;
            req_idx <= bus_idx;
            req_dat <= BUS_WRITE;
            cnt     <= CNT_LOAD;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // Inputs are ignored here; the latched copy drives completion.
          if (cnt == 8'd0) begin
            if (!req_wr) begin
              BUS_READ <= mem[req_idx];
            end
            BUS_R <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          // Release only once the initiator drops its request; the fall lands us in IDLE,
          // so the next request is taken no earlier than the following edge.
          if (!BUS_EN) begin
            BUS_R <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          BUS_R <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Line write commits on the completing edge, before BUS_R is seen.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      mem[req_idx] <= req_dat;
    end
  end

`ifdef MEM_RESP_STATS_EN
  // Saturating transfer counters, bumped on the BUSY->RESP edge.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (done) begin
      if (req_wr) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_line_responder.sv
// tb_mem_line_responder: randomized and directed line transfers against a transaction-level model.
// Latency: model predicts BUS_R per cycle from acceptance time + LATENCY.
// Backpressure: initiator holds BUS_EN in RESP for 1..3 cycles or drops it early during BUSY.
module tb_mem_line_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         bus_en;
  logic         bus_wr;
  logic [15:0]  bus_addr;
  logic [127:0] bus_write;
  logic         bus_r;
  logic [127:0] bus_read;
`ifdef MEM_RESP_STATS_EN
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
`endif

  mem_line_responder #(
    .ADDR_W (16),
    .LINE_W (128),
    .IDX_W  (12),
    .LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .BUS_EN   (bus_en),
    .BUS_WR   (bus_wr),
    .BUS_ADDR (bus_addr),
    .BUS_WRITE(bus_write),
    .BUS_R    (bus_r),
    .BUS_READ (bus_read)
`ifdef MEM_RESP_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  always #5 clk = ~clk;

  // Model state: line store keyed by index, expected outputs, expected counters.
  logic [127:0] model_mem [int];
  int           written [$];
  logic         exp_r;
  logic [127:0] exp_read;
  int           exp_rd_cnt;
  int           exp_wr_cnt;
  logic         chk_en = 1'b0;
  int           checks = 0;
  int           errors = 0;

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("bus_r", {127'd0, bus_r}, {127'd0, exp_r});
      check("bus_read", bus_read, exp_read);
`ifdef MEM_RESP_STATS_EN
      check("rd_count", {112'd0, rd_count}, 128'(exp_rd_cnt));
      check("wr_count", {112'd0, wr_count}, 128'(exp_wr_cnt));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    bus_wr    = 1'($urandom);
    bus_addr  = 16'($urandom);
    bus_write = rand128();
  endtask

  // One transfer from IDLE: BUS_R expected exactly LAT edges after acceptance, held for
  // 'hold' cycles while BUS_EN stays high; drop_at>=0 drops BUS_EN that many edges into BUSY.
  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [127:0] data,
                      input int hold, input int drop_at);
    int idx;
    idx       = int'(addr[15:4]);
    bus_en    = 1'b1;
    bus_wr    = wr;
    bus_addr  = addr;
    bus_write = data;
    step();                       // acceptance edge
    exp_r = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      if (k == drop_at) bus_en = 1'b0;
      scramble();
      step();
      if (k < LAT - 1) begin
        exp_r = 1'b0;
      end else begin
        exp_r = 1'b1;
        if (wr) begin
          model_mem[idx] = data;
          written.push_back(idx);
          exp_wr_cnt++;
        end else begin
          exp_read = model_mem[idx];
          exp_rd_cnt++;
        end
      end
    end
    if (drop_at < 0) begin
      for (int h = 1; h < hold; h++) begin
        scramble();
        step();
        exp_r = 1'b1;
      end
      bus_en = 1'b0;
    end
    step();
    exp_r = 1'b0;
  endtask

  initial begin
    exp_r      = 1'b0;
    exp_read   = '0;
    exp_rd_cnt = 0;
    exp_wr_cnt = 0;

    // Reset held two cycles with a pending request: nothing accepted.
    clr       = 1'b1;
    bus_en    = 1'b1;
    bus_wr    = 1'b1;
    bus_addr  = 16'h0120;
    bus_write = {16{8'hA5}};
    step();
    chk_en = 1'b1;
    step();
    check("rst_bus_r", {127'd0, bus_r}, 128'd0);
    check("rst_bus_read", bus_read, 128'd0);
    clr = 1'b0;

    // Write then read of the same line (different byte offset).
    xfer(1'b1, 16'h0120, {16{8'hA5}}, 1, -1);
    xfer(1'b0, 16'h012F, 128'd0, 1, -1);
    check("rd_after_wr", bus_read, {16{8'hA5}});

    // Back-to-back with BUS_R held three cycles.
    xfer(1'b0, 16'h0125, 128'd0, 3, -1);
    xfer(1'b1, 16'h0300, 128'hDEAD_BEEF, 3, -1);
    check("b2b_hold_read", bus_read, {16{8'hA5}});

    // Initiator drops BUS_EN during BUSY: write still commits, one-cycle BUS_R.
    xfer(1'b1, 16'h0040, 128'h1234, 1, 1);
    xfer(1'b0, 16'h0040, 128'd0, 1, -1);
    check("abort_wr_read", bus_read, 128'h1234);

    // Reset mid-write: uncommitted data dropped, BUS_R never rises.
    xfer(1'b1, 16'h0200, 128'd0, 1, -1);
    bus_en    = 1'b1;
    bus_wr    = 1'b1;
    bus_addr  = 16'h0200;
    bus_write = {16{8'hFF}};
    step();
    step();
    clr    = 1'b1;
    bus_en = 1'b0;
    step();
    exp_r      = 1'b0;
    exp_read   = '0;
    exp_rd_cnt = 0;
    exp_wr_cnt = 0;
    clr = 1'b0;
    repeat (LAT + 2) step();
    xfer(1'b0, 16'h0200, 128'd0, 1, -1);
    check("rst_mid_wr_read", bus_read, 128'd0);
    xfer(1'b0, 16'h0300, 128'd0, 2, -1);
    check("line_300_read", bus_read, 128'hDEAD_BEEF);

    // Randomized transfers.
    for (int t = 0; t < 60; t++) begin
      logic        wr;
      logic [15:0] addr;
      int          hold;
      int          drop;
      int          idx;
      wr = ($urandom_range(0, 1) == 1);
      if (wr) begin
        addr = 16'($urandom);
      end else begin
        idx  = written[$urandom_range(0, written.size() - 1)];
        addr = {idx[11:0], 4'($urandom)};
      end
      hold = $urandom_range(1, 3);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, LAT - 1) : -1;
      xfer(wr, addr, rand128(), hold, drop);
      repeat ($urandom_range(0, 2)) step();
    end

`ifdef MEM_RESP_STATS_EN
    // Counter pinning: clr, then 2 writes + 3 reads, then clr again.
    clr = 1'b1;
    step();
    exp_r      = 1'b0;
    exp_read   = '0;
    exp_rd_cnt = 0;
    exp_wr_cnt = 0;
    clr = 1'b0;
    xfer(1'b1, 16'h0500, 128'h55, 1, -1);
    xfer(1'b1, 16'h0510, 128'h66, 2, -1);
    xfer(1'b0, 16'h0500, 128'd0, 1, -1);
    xfer(1'b0, 16'h0510, 128'd0, 1, 0);
    xfer(1'b0, 16'h0040, 128'd0, 3, -1);
    check("stat_rd3", {112'd0, rd_count}, 128'd3);
    check("stat_wr2", {112'd0, wr_count}, 128'd2);
    clr = 1'b1;
    step();
    exp_read   = '0;
    exp_rd_cnt = 0;
    exp_wr_cnt = 0;
    clr = 1'b0;
    check("stat_rd_clr", {112'd0, rd_count}, 128'd0);
    check("stat_wr_clr", {112'd0, wr_count}, 128'd0);
`endif

    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
